// File: rtl/ask_mlevel_keying_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ask_pkg
// Description : Shared types and helpers for the ASK keying controller:
//               controller state encoding, the level-spacing calculation
//               and the slew-limited ramp step.
// Revision    : 1.0 - initial release
// ============================================================================
package ask_pkg;

   // Controller states. The encoding is fixed so it stays stable across
   // blocks that decode it from a status register.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OOK   = 3'd1,
      ST_RAMP  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } ask_state_e;

   // Spacing between adjacent amplitude levels so that the top level lands
   // as close to full scale as integer division allows.
   function automatic int unsigned level_step(input int unsigned bits_per_sym,
                                              input int unsigned amp_w);
      int unsigned full_scale;
      int unsigned n_gaps;
      full_scale = (32'd1 << amp_w) - 32'd1;
      n_gaps     = (32'd1 << bits_per_sym) - 32'd1;
      return full_scale / n_gaps;
   endfunction

   // One slew-limited step of amp toward target. Working on the distance
   // to the target instead of amp+step keeps the arithmetic from wrapping.
   function automatic int unsigned ramp_next(input int unsigned amp,
                                             input int unsigned target,
                                             input int unsigned step);
      int unsigned result;
      result = amp;
      if (amp < target) begin
         result = ((target - amp) > step) ? (amp + step) : target;
      end else if (amp > target) begin
         result = ((amp - target) > step) ? (amp - step) : target;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ask_mlevel_keying_controller_bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Multi-flop synchroniser for a single asynchronous bit.
//               Asynchronous active-high reset clears the whole chain.
// Ports       : clk      - destination clock
//               reset    - asynchronous, active-high
//               i_async  - asynchronous input bit
//               o_sync   - input bit after STAGES destination-clock flops
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ask_mlevel_keying_controller.sv
`default_nettype none
// ============================================================================
// Module      : ask_mlevel_keying_controller
// Description : Amplitude-word generator for the ASK carrier multiplier.
//               Legacy OOK from an asynchronous key, or M-ASK from a
//               valid/ready symbol stream with fixed symbol length.
//               All amplitude changes are slew-limited by RAMP_STEP.
// Ports       : clk        - clock
//               reset      - asynchronous, active-high
//               enable     - run request; mode sampled only while idle
//               mode       - 0 = OOK from key_in, 1 = M-ASK symbol stream
//               key_in     - asynchronous OOK key
//               sym_valid  - symbol available
//               sym_data   - symbol code 0..2^BITS_PER_SYM-1
//               sym_ready  - symbol accepted when sym_valid & sym_ready
//               amp_out    - registered amplitude word
//               sym_strobe - one-cycle pulse per accepted symbol
//               underrun   - one-cycle pulse when a slot ends with no symbol
//               busy       - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ask_mlevel_keying_controller #(
   parameter int BITS_PER_SYM = 2,
   parameter int AMP_W        = 8,
   parameter int SYM_CYCLES   = 8,
   parameter int RAMP_STEP    = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    mode,
   input  logic                    key_in,
   input  logic                    sym_valid,
   input  logic [BITS_PER_SYM-1:0] sym_data,
   output logic                    sym_ready,
   output logic [AMP_W-1:0]        amp_out,
   output logic                    sym_strobe,
   output logic                    underrun,
   output logic                    busy
);

   import ask_pkg::*;

   localparam int unsigned c_levels     = 32'd1 << BITS_PER_SYM;
   localparam int unsigned c_level_step = level_step(BITS_PER_SYM, AMP_W);
   localparam logic [AMP_W-1:0] c_amp_max = AMP_W'((c_levels - 32'd1) * c_level_step);

   localparam int c_timer_w = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
   localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(SYM_CYCLES - 1);

   localparam logic [2:0] c_st_idle  = ST_IDLE;
   localparam logic [2:0] c_st_ook   = ST_OOK;
   localparam logic [2:0] c_st_ramp  = ST_RAMP;
   localparam logic [2:0] c_st_hold  = ST_HOLD;
   localparam logic [2:0] c_st_drain = ST_DRAIN;

   logic [2:0]           r_state;
   logic [AMP_W-1:0]     r_amp;
   logic [AMP_W-1:0]     r_target;
   logic [c_timer_w-1:0] r_timer;
   logic                 r_sym_strobe;
   logic                 r_underrun;

   logic [2:0]           w_state_nxt;
   logic [AMP_W-1:0]     w_amp_nxt;
   logic [AMP_W-1:0]     w_target_nxt;
   logic [c_timer_w-1:0] w_timer_nxt;
   logic                 w_strobe_nxt;
   logic                 w_underrun_nxt;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_in_symbol;
   logic                 w_sym_end;
   logic                 w_key_sync;
   logic [AMP_W-1:0]     w_level;

   // ------------------------------------------------------------------------
   // Key synchroniser: runs in every state so the OOK path sees a settled
   // key as soon as it is entered.
   // ------------------------------------------------------------------------
   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_key_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (key_in),
      .o_sync  (w_key_sync)
   );

   assign w_level = AMP_W'(32'(sym_data) * c_level_step);

   // ------------------------------------------------------------------------
   // Next-state logic. Target is resolved first, then the ramp step is taken
   // toward the target being loaded on this same edge, so a newly accepted
   // symbol moves amp_out on the very next edge, even from mid-ramp.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_target_nxt   = r_target;
      w_timer_nxt    = r_timer;
      w_strobe_nxt   = 1'b0;
      w_underrun_nxt = 1'b0;
      w_ready        = 1'b0;
      w_accept       = 1'b0;
      w_in_symbol    = (r_state == c_st_ramp) || (r_state == c_st_hold);
      w_sym_end      = w_in_symbol && (r_timer == c_timer_last);

      case (r_state)
         c_st_idle: begin
            w_target_nxt = '0;
            w_timer_nxt  = '0;
            w_ready      = enable && mode;
            if (enable && !mode) begin
               w_state_nxt = c_st_ook;
            end
         end

         c_st_ook: begin
            if (!enable) begin
               w_target_nxt = '0;
               w_state_nxt  = c_st_drain;
            end else begin
               w_target_nxt = w_key_sync ? c_amp_max : '0;
            end
         end

         c_st_ramp, c_st_hold: begin
            if (w_sym_end) begin
               // The running symbol is always completed; only at its last
               // cycle is the next one requested or the output wound down.
               w_ready = enable;
               if (!enable) begin
                  w_target_nxt = '0;
                  w_state_nxt  = c_st_drain;
               end else if (!sym_valid) begin
                  w_underrun_nxt = 1'b1;
                  w_target_nxt   = '0;
                  w_state_nxt    = c_st_drain;
               end
            end else begin
               w_timer_nxt = r_timer + c_timer_w'(1);
            end
         end

         c_st_drain: begin
            w_target_nxt = '0;
            if (r_amp == '0) begin
               w_state_nxt = c_st_idle;
            end
         end

         default: begin
            w_target_nxt = '0;
            w_state_nxt  = c_st_drain;
         end
      endcase

      w_accept = w_ready && sym_valid;
      if (w_accept) begin
         w_target_nxt = w_level;
         w_timer_nxt  = '0;
         w_strobe_nxt = 1'b1;
      end

      w_amp_nxt = AMP_W'(ramp_next(32'(r_amp), 32'(w_target_nxt), 32'(RAMP_STEP)));

      if (w_accept || (w_in_symbol && !w_sym_end)) begin
         w_state_nxt = (w_amp_nxt == w_target_nxt) ? c_st_hold : c_st_ramp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_amp        <= '0;
         r_target     <= '0;
         r_timer      <= '0;
         r_sym_strobe <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_amp        <= w_amp_nxt;
         r_target     <= w_target_nxt;
         r_timer      <= w_timer_nxt;
         r_sym_strobe <= w_strobe_nxt;
         r_underrun   <= w_underrun_nxt;
      end
   end

   // sym_ready is decoded from state, timer, enable and mode only. Reset
   // gates it so it drops at once even if enable/mode are held high.
   assign sym_ready  = w_ready && !reset;
   assign amp_out    = r_amp;
   assign sym_strobe = r_sym_strobe;
   assign underrun   = r_underrun;
   assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_ask_mlevel_keying_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ask_mlevel_keying_controller
// Description : Bench for ask_mlevel_keying_controller. Two instances share
//               the stimulus: one with a 32-per-clock ramp, one with
//               instant steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ask_mlevel_keying_controller;

   localparam int BPS    = 2;
   localparam int AW     = 8;
   localparam int SYMC   = 8;
   localparam int SS     = 2;
   localparam int STEP_A = 32;
   localparam int STEP_B = 255;
   localparam int NLEV   = 1 << BPS;
   localparam int LSTEP  = ((1 << AW) - 1) / (NLEV - 1);
   localparam int AMAX   = (NLEV - 1) * LSTEP;

   localparam int P_IDLE  = 0;
   localparam int P_KEY   = 1;
   localparam int P_SYM   = 2;
   localparam int P_DRAIN = 3;

   logic           clk       = 1'b0;
   logic           reset     = 1'b0;
   logic           enable    = 1'b0;
   logic           mode      = 1'b0;
   logic           key_in    = 1'b0;
   logic           sym_valid = 1'b0;
   logic [BPS-1:0] sym_data  = '0;

   logic          rdy_a, stb_a, und_a, busy_a;
   logic          rdy_b, stb_b, und_b, busy_b;
   logic [AW-1:0] amp_a, amp_b;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   typedef struct {
      int ph;
      int amp;
      int tgt;
      int tmr;
      bit strobe;
      bit und;
   } m_t;

   m_t            ma, mb;
   logic [SS-1:0] khist;

   int t1_up[8] = '{32, 64, 96, 128, 160, 170, 170, 170};
   int t2_up[8] = '{32, 64, 96, 128, 160, 192, 224, 255};
   int t2_dn[8] = '{223, 191, 159, 127, 95, 63, 31, 0};
   int t3_up[8] = '{32, 64, 85, 85, 85, 85, 85, 85};
   int t6_dn[6] = '{138, 106, 74, 42, 10, 0};

   always #5 clk = ~clk;

   ask_mlevel_keying_controller #(
      .BITS_PER_SYM (BPS), .AMP_W (AW), .SYM_CYCLES (SYMC),
      .RAMP_STEP (STEP_A), .SYNC_STAGES (SS)
   ) dut_a (
      .clk (clk), .reset (reset), .enable (enable), .mode (mode),
      .key_in (key_in), .sym_valid (sym_valid), .sym_data (sym_data),
      .sym_ready (rdy_a), .amp_out (amp_a), .sym_strobe (stb_a),
      .underrun (und_a), .busy (busy_a)
   );

   ask_mlevel_keying_controller #(
      .BITS_PER_SYM (BPS), .AMP_W (AW), .SYM_CYCLES (SYMC),
      .RAMP_STEP (STEP_B), .SYNC_STAGES (SS)
   ) dut_b (
      .clk (clk), .reset (reset), .enable (enable), .mode (mode),
      .key_in (key_in), .sym_valid (sym_valid), .sym_data (sym_data),
      .sym_ready (rdy_b), .amp_out (amp_b), .sym_strobe (stb_b),
      .underrun (und_b), .busy (busy_b)
   );

   // ---------------------------------------------------------------- model
   function automatic m_t m_clear();
      m_t m;
      m.ph = P_IDLE; m.amp = 0; m.tgt = 0; m.tmr = 0; m.strobe = 1'b0; m.und = 1'b0;
      return m;
   endfunction

   function automatic bit m_ready(m_t m, bit en, bit md);
      return (m.ph == P_IDLE && en && md) || (m.ph == P_SYM && m.tmr == SYMC - 1 && en);
   endfunction

   function automatic m_t m_step(m_t m, int step, bit en, bit md, bit ks, bit sv, int sd);
      m_t n;
      bit take;
      n = m;
      n.strobe = 1'b0;
      n.und    = 1'b0;
      take = m_ready(m, en, md) && sv;
      case (m.ph)
         P_IDLE: begin
            n.tgt = 0;
            if (en && !md) n.ph = P_KEY;
         end
         P_KEY: begin
            n.tgt = (en && ks) ? AMAX : 0;
            if (!en) n.ph = P_DRAIN;
         end
         P_SYM: begin
            if (m.tmr < SYMC - 1) n.tmr = m.tmr + 1;
            else if (!take) begin
               n.tgt = 0;
               n.ph  = P_DRAIN;
               n.und = en;
            end
         end
         P_DRAIN: begin
            n.tgt = 0;
            if (m.amp == 0) n.ph = P_IDLE;
         end
         default: n.ph = P_IDLE;
      endcase
      if (take) begin
         n.ph = P_SYM; n.tgt = sd * LSTEP; n.tmr = 0; n.strobe = 1'b1;
      end
      if (n.tgt > m.amp)      n.amp = (n.tgt - m.amp > step) ? m.amp + step : n.tgt;
      else if (n.tgt < m.amp) n.amp = (m.amp - n.tgt > step) ? m.amp - step : n.tgt;
      else                    n.amp = n.tgt;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma    <= m_clear();
         mb    <= m_clear();
         khist <= '0;
      end else begin
         ma    <= m_step(ma, STEP_A, enable, mode, khist[SS-1], sym_valid, int'(sym_data));
         mb    <= m_step(mb, STEP_B, enable, mode, khist[SS-1], sym_valid, int'(sym_data));
         khist <= {khist[SS-2:0], key_in};
      end
   end

   // ---------------------------------------------------------- comparisons
   task automatic check(string name, logic [31:0] act, int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_dut(string tag, m_t m, logic [AW-1:0] amp, logic rdy,
                              logic stb, logic und, logic bsy);
      check($sformatf("%s amp_out", tag),    32'(amp), m.amp);
      check($sformatf("%s sym_ready", tag),  32'(rdy), int'(!reset && m_ready(m, enable, mode)));
      check($sformatf("%s sym_strobe", tag), 32'(stb), int'(m.strobe));
      check($sformatf("%s underrun", tag),   32'(und), int'(m.und));
      check($sformatf("%s busy", tag),       32'(bsy), int'(m.ph != P_IDLE));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         compare_dut("A", ma, amp_a, rdy_a, stb_a, und_a, busy_a);
         compare_dut("B", mb, amp_b, rdy_b, stb_b, und_b, busy_b);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(string name, int budget);
      int k;
      k = 0;
      while ((busy_a || busy_b) && k < budget) begin
         tick();
         k++;
      end
      check({name, " returns to idle"}, 32'(busy_a || busy_b), 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 chk_on = 1'b1;
      check("reset amp_out", 32'(amp_a), 0);
      check("reset busy", 32'(busy_a), 0);
      check("reset sym_ready", 32'(rdy_a), 0);
      check("reset sym_strobe", 32'(stb_a), 0);
      check("reset underrun", 32'(und_a), 0);
      tick();
      tick();
      reset = 1'b0;

      // single symbol k=2, ramp to 170
      mode = 1'b1; enable = 1'b1; sym_data = 2'd2; sym_valid = 1'b1;
      #1 check("T1 sym_ready idle", 32'(rdy_a), 1);
      tick();
      sym_valid = 1'b0;
      check("T1 sym_strobe", 32'(stb_a), 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("T1 amp[%0d]", i), 32'(amp_a), t1_up[i]);
         if (i == 1) check("T1 strobe single", 32'(stb_a), 0);
         tick();
      end
      wait_idle("T1", 40);

      // back-to-back 3 then 0
      sym_data = 2'd3; sym_valid = 1'b1;
      tick();
      sym_data = 2'd0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("T2 up amp[%0d]", i), 32'(amp_a), t2_up[i]);
         check($sformatf("T2 ready[%0d]", i), 32'(rdy_a), int'(i == 7));
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("T2 dn amp[%0d]", i), 32'(amp_a), t2_dn[i]);
         check($sformatf("T2 underrun[%0d]", i), 32'(und_a), 0);
         if (i == 7) begin
            sym_valid = 1'b0;
            enable    = 1'b0;
         end
         tick();
      end
      check("T2 no underrun at stop", 32'(und_a), 0);
      wait_idle("T2", 20);

      // underrun after one k=1 symbol
      enable = 1'b1; mode = 1'b1; sym_data = 2'd1; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("T3 amp[%0d]", i), 32'(amp_a), t3_up[i]);
         tick();
      end
      check("T3 underrun pulse", 32'(und_a), 1);
      check("T3 drain 53", 32'(amp_a), 53);
      tick();
      check("T3 underrun one cycle", 32'(und_a), 0);
      check("T3 drain 21", 32'(amp_a), 21);
      tick();
      check("T3 drain 0", 32'(amp_a), 0);
      wait_idle("T3", 20);
      enable = 1'b0;
      tick();

      // OOK with instant steps on dut_b
      mode = 1'b0; enable = 1'b1; key_in = 1'b0;
      tick();
      check("T4 busy in OOK", 32'(busy_b), 1);
      tick();
      tick();
      key_in = 1'b1; sym_valid = 1'b1; sym_data = 2'd3;
      tick();
      check("T4 rise edge1", 32'(amp_b), 0);
      check("T4 ready low", 32'(rdy_b), 0);
      tick();
      check("T4 rise edge2", 32'(amp_b), 0);
      tick();
      check("T4 rise edge3", 32'(amp_b), 255);
      key_in = 1'b0;
      tick();
      check("T4 fall edge1", 32'(amp_b), 255);
      tick();
      check("T4 fall edge2", 32'(amp_b), 255);
      tick();
      check("T4 fall edge3", 32'(amp_b), 0);
      check("T4 no strobe", 32'(stb_b), 0);
      sym_valid = 1'b0; enable = 1'b0;
      wait_idle("T4", 30);

      // asynchronous reset mid-ramp
      mode = 1'b1; enable = 1'b1; sym_data = 2'd2; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      tick();
      tick();
      check("T5 amp before reset", 32'(amp_a), 96);
      #1 reset = 1'b1;
      #1;
      check("T5 async amp_out", 32'(amp_a), 0);
      check("T5 async busy", 32'(busy_a), 0);
      check("T5 async sym_ready", 32'(rdy_a), 0);
      tick();
      reset = 1'b0; sym_data = 2'd3; sym_valid = 1'b1;
      #1 check("T5 ready after release", 32'(rdy_a), 1);
      tick();
      sym_valid = 1'b0;
      check("T5 ramp from 0", 32'(amp_a), 32);
      wait_idle("T5", 40);

      // enable and mode dropped mid-symbol while holding 170
      sym_data = 2'd2; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("T6 amp[%0d]", i), 32'(amp_a), t1_up[i]);
         if (i == 5) begin
            enable = 1'b0;
            mode   = 1'b0;
         end
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         check($sformatf("T6 drain amp[%0d]", i), 32'(amp_a), t6_dn[i]);
         check($sformatf("T6 drain busy[%0d]", i), 32'(busy_a), 1);
         check($sformatf("T6 drain underrun[%0d]", i), 32'(und_a), 0);
         tick();
      end
      check("T6 idle after drain", 32'(busy_a), 0);
      enable = 1'b1;
      tick();
      check("T6 new mode OOK busy", 32'(busy_a), 1);
      check("T6 new mode ready low", 32'(rdy_a), 0);
      enable = 1'b0;
      wait_idle("T6", 20);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
